// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep monitor.
//
// Contents:
//   digit_idx_t - index of the display digit currently being scanned (0..3)
//   bcd2_t      - two-digit BCD value {tens, ones}
//   Glyph*      - active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   bcd2_inc    - BCD increment with 99 -> 00 rollover
package sweep_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [7:0] bcd2_t;

  // Hex digit glyphs
  localparam logic [6:0] GlyphHex0 = 7'b1000000;
  localparam logic [6:0] GlyphHex1 = 7'b1111001;
  localparam logic [6:0] GlyphHex2 = 7'b0100100;
  localparam logic [6:0] GlyphHex3 = 7'b0110000;
  localparam logic [6:0] GlyphHex4 = 7'b0011001;
  localparam logic [6:0] GlyphHex5 = 7'b0010010;
  localparam logic [6:0] GlyphHex6 = 7'b0000010;
  localparam logic [6:0] GlyphHex7 = 7'b1111000;
  localparam logic [6:0] GlyphHex8 = 7'b0000000;
  localparam logic [6:0] GlyphHex9 = 7'b0010000;
  localparam logic [6:0] GlyphHexA = 7'b0001000;
  localparam logic [6:0] GlyphHexB = 7'b0000011;
  localparam logic [6:0] GlyphHexC = 7'b1000110;
  localparam logic [6:0] GlyphHexD = 7'b0100001;
  localparam logic [6:0] GlyphHexE = 7'b0000110;
  localparam logic [6:0] GlyphHexF = 7'b0001110;

  // Status glyphs for the direction digit
  localparam logic [6:0] GlyphU     = 7'b1000001;
  localparam logic [6:0] GlyphD     = 7'b0100001;
  localparam logic [6:0] GlyphE     = 7'b0000110;
  localparam logic [6:0] GlyphBlank = 7'b1111111;

  // Increment a two-digit BCD value; ones carry into tens, 99 rolls to 00.
  function automatic bcd2_t bcd2_inc(input bcd2_t value);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = value[3:0];
    tens = value[7:4];
    if (ones >= 4'd9) begin
      ones = 4'd0;
      tens = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/sweep_monitor_hex7seg.sv
// Combinational hex to active-low 7-segment decoder.
//
// Ports:
//   hex_i - 4-bit value to show
//   seg_o - segment drive {g,f,e,d,c,b,a}, active-low
module hex7seg
  import sweep_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GlyphBlank;
    case (hex_i)
      4'h0: seg_o = GlyphHex0;
      4'h1: seg_o = GlyphHex1;
      4'h2: seg_o = GlyphHex2;
      4'h3: seg_o = GlyphHex3;
      4'h4: seg_o = GlyphHex4;
      4'h5: seg_o = GlyphHex5;
      4'h6: seg_o = GlyphHex6;
      4'h7: seg_o = GlyphHex7;
      4'h8: seg_o = GlyphHex8;
      4'h9: seg_o = GlyphHex9;
      4'hA: seg_o = GlyphHexA;
      4'hB: seg_o = GlyphHexB;
      4'hC: seg_o = GlyphHexC;
      4'hD: seg_o = GlyphHexD;
      4'hE: seg_o = GlyphHexE;
      4'hF: seg_o = GlyphHexF;
      default: seg_o = GlyphBlank;
    endcase
  end

endmodule

// File: rtl/sweep_monitor.sv
// Monitor for a 4-bit up/down ping-pong counter (0 -> 15 -> 0 -> ...).
//
// Samples the counter every clock and reports the sweep direction, a pulse
// at each top reversal, a BCD count of completed sweeps (counted at each
// trough reversal) and a sticky illegal-step flag. The same state is shown
// on a 4-digit multiplexed active-low 7-segment display:
//   digit0 = last sampled value (hex), digit1 = U / d / E,
//   digit2 = sweep count ones,         digit3 = sweep count tens.
//
// Ports:
//   clock    - system clock
//   reset    - asynchronous, active-high reset
//   sa       - counter value from upstream
//   clear    - synchronous clear of cycles and step_err
//   dir      - 0 = ascending, 1 = descending
//   peak     - one-cycle pulse on top reversal
//   cycles   - BCD sweep count {tens, ones}
//   step_err - sticky illegal-step flag
//   an       - digit enables, active-low one-hot
//   seg      - segments {g,f,e,d,c,b,a}, active-low
module sweep_monitor
  import sweep_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sa,
  input  logic       clear,
  output logic       dir,
  output logic       peak,
  output logic [7:0] cycles,
  output logic       step_err,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned ScanW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [ScanW-1:0] ScanLast = ScanW'(REFRESH_DIV - 1);

  // Sampler / direction state
  logic       primed_q, primed_d;
  logic [3:0] prev_q, prev_d;
  logic       dir_q, dir_d;
  logic       peak_q, peak_d;
  bcd2_t      cycles_q, cycles_d;
  logic       step_err_q, step_err_d;

  // Display scan state
  logic [ScanW-1:0] scan_q, scan_d;
  digit_idx_t       digit_q, digit_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  // Step classification. Compared at 5 bits so 15 -> 0 and 0 -> 15 are not
  // mistaken for legal +/-1 steps.
  logic step_up;
  logic step_down;
  logic step_hold;

  assign step_up   = ({1'b0, sa} == ({1'b0, prev_q} + 5'd1));
  assign step_down = (({1'b0, sa} + 5'd1) == {1'b0, prev_q});
  assign step_hold = (sa == prev_q);

  always_comb begin
    primed_d   = 1'b1;
    prev_d     = sa;
    dir_d      = dir_q;
    peak_d     = 1'b0;
    cycles_d   = cycles_q;
    step_err_d = step_err_q;

    // The first sample after reset only seeds prev.
    if (primed_q) begin
      if (step_up) begin
        if (dir_q) begin
          dir_d    = 1'b0;
          cycles_d = bcd2_inc(cycles_q);
        end
      end else if (step_down) begin
        if (!dir_q) begin
          dir_d  = 1'b1;
          peak_d = 1'b1;
        end
      end else if (!step_hold) begin
        step_err_d = 1'b1;
      end
    end

    // Clear takes priority over a same-edge increment or error.
    if (clear) begin
      cycles_d   = '0;
      step_err_d = 1'b0;
    end
  end

  // Scan counter: each digit stays enabled for REFRESH_DIV clocks.
  logic scan_wrap;

  assign scan_wrap = (scan_q == ScanLast);

  always_comb begin
    scan_d  = scan_q + ScanW'(1);
    digit_d = digit_q;
    if (scan_wrap) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // Digit content. A single decoder serves all hex digits; digit1 is a
  // status glyph and bypasses it.
  logic [3:0] disp_hex;
  logic [6:0] hex_seg;
  logic [6:0] dir_glyph;

  always_comb begin
    disp_hex = prev_q;
    unique case (digit_q)
      2'd0:    disp_hex = prev_q;
      2'd1:    disp_hex = prev_q;
      2'd2:    disp_hex = cycles_q[3:0];
      2'd3:    disp_hex = cycles_q[7:4];
      default: disp_hex = prev_q;
    endcase
  end

  hex7seg u_hex7seg (
    .hex_i (disp_hex),
    .seg_o (hex_seg)
  );

  always_comb begin
    if (step_err_q) begin
      dir_glyph = GlyphE;
    end else if (dir_q) begin
      dir_glyph = GlyphD;
    end else begin
      dir_glyph = GlyphU;
    end
  end

  always_comb begin
    an_d  = ~(4'b0001 << digit_q);
    seg_d = (digit_q == 2'd1) ? dir_glyph : hex_seg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      primed_q   <= 1'b0;
      prev_q     <= 4'd0;
      dir_q      <= 1'b0;
      peak_q     <= 1'b0;
      cycles_q   <= '0;
      step_err_q <= 1'b0;
      scan_q     <= '0;
      digit_q    <= '0;
      an_q       <= 4'b1111;
      seg_q      <= GlyphBlank;
    end else begin
      primed_q   <= primed_d;
      prev_q     <= prev_d;
      dir_q      <= dir_d;
      peak_q     <= peak_d;
      cycles_q   <= cycles_d;
      step_err_q <= step_err_d;
      scan_q     <= scan_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign dir      = dir_q;
  assign peak     = peak_q;
  assign cycles   = cycles_q;
  assign step_err = step_err_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_sweep_monitor.sv
// Bench for sweep_monitor: a behavioural model checked every cycle plus
// hand-computed pins at the interesting points of each scenario.
module tb_sweep_monitor;

  localparam int Div = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sa;
  logic       clear;
  logic       dir;
  logic       peak;
  logic [7:0] cycles;
  logic       step_err;
  logic [3:0] an;
  logic [6:0] seg;

  sweep_monitor #(
    .REFRESH_DIV (Div)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .sa       (sa),
    .clear    (clear),
    .dir      (dir),
    .peak     (peak),
    .cycles   (cycles),
    .step_err (step_err),
    .an       (an),
    .seg      (seg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // ---------------- behavioural model ----------------
  bit         m_primed;
  int         m_prev;
  bit         m_dir;
  bit         m_peak;
  int         m_count;   // plain decimal 0..99
  bit         m_err;
  int         m_edges;   // clock edges since reset
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [6:0] glyph_hex(input int v);
    case (v)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
     12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] digit_glyph(input int d);
    case (d)
      0: return glyph_hex(m_prev);
      1: return m_err ? 7'h06 : (m_dir ? 7'h21 : 7'h41);
      2: return glyph_hex(m_count % 10);
      default: return glyph_hex(m_count / 10);
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int c);
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_primed <= 1'b0;
      m_prev   <= 0;
      m_dir    <= 1'b0;
      m_peak   <= 1'b0;
      m_count  <= 0;
      m_err    <= 1'b0;
      m_edges  <= 0;
      m_an     <= 4'hF;
      m_seg    <= 7'h7F;
    end else begin
      m_edges  <= m_edges + 1;
      m_an     <= ~(4'b0001 << ((m_edges / Div) % 4));
      m_seg    <= digit_glyph((m_edges / Div) % 4);
      m_peak   <= 1'b0;
      m_prev   <= int'(sa);
      m_primed <= 1'b1;
      if (m_primed) begin
        if (int'(sa) == m_prev + 1) begin
          if (m_dir) begin
            m_dir   <= 1'b0;
            m_count <= (m_count + 1) % 100;
          end
        end else if (int'(sa) == m_prev - 1) begin
          if (!m_dir) begin
            m_dir  <= 1'b1;
            m_peak <= 1'b1;
          end
        end else if (int'(sa) != m_prev) begin
          m_err <= 1'b1;
        end
      end
      if (clear) begin
        m_count <= 0;
        m_err   <= 1'b0;
      end
    end
  end

  // ---------------- hand-computed pins ----------------
  int         st_tag = 0;
  string      st_lbl;
  bit         st_dir, st_peak, st_err;
  logic [7:0] st_cyc;
  int         dp_tag = 0;
  string      dp_lbl;
  logic [3:0] dp_an;
  logic [6:0] dp_seg;

  task automatic pin_st(input string lbl, input bit d, input bit p, input logic [7:0] c,
                        input bit e);
    st_lbl  = lbl;
    st_dir  = d;
    st_peak = p;
    st_cyc  = c;
    st_err  = e;
    st_tag++;
  endtask

  task automatic pin_dp(input string lbl, input logic [3:0] a, input logic [6:0] s);
    dp_lbl = lbl;
    dp_an  = a;
    dp_seg = s;
    dp_tag++;
  endtask

  // ---------------- compare process ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : compare
    int st_seen;
    int dp_seen;
    st_seen = 0;
    dp_seen = 0;
    forever begin
      @(negedge clock);
      chk("model.dir", 32'(dir), 32'(m_dir));
      chk("model.peak", 32'(peak), 32'(m_peak));
      chk("model.cycles", 32'(cycles), 32'(to_bcd(m_count)));
      chk("model.step_err", 32'(step_err), 32'(m_err));
      chk("model.an", 32'(an), 32'(m_an));
      chk("model.seg", 32'(seg), 32'(m_seg));
      if (st_tag != st_seen) begin
        st_seen = st_tag;
        chk({st_lbl, ".dir"}, 32'(dir), 32'(st_dir));
        chk({st_lbl, ".peak"}, 32'(peak), 32'(st_peak));
        chk({st_lbl, ".cycles"}, 32'(cycles), 32'(st_cyc));
        chk({st_lbl, ".step_err"}, 32'(step_err), 32'(st_err));
      end
      if (dp_tag != dp_seen) begin
        dp_seen = dp_tag;
        chk({dp_lbl, ".an"}, 32'(an), 32'(dp_an));
        chk({dp_lbl, ".seg"}, 32'(seg), 32'(dp_seg));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] v);
    @(negedge clock);
    sa    = v;
    clear = 1'b0;
    @(posedge clock);
    edge_cnt++;
    #1;
  endtask

  task automatic step_clr(input logic [3:0] v);
    @(negedge clock);
    sa    = v;
    clear = 1'b1;
    @(posedge clock);
    edge_cnt++;
    #1;
  endtask

  // One full sweep starting and ending at sa=1 while ascending.
  task automatic sweep();
    for (int v = 2; v <= 15; v++) step(4'(v));
    for (int v = 14; v >= 0; v--) step(4'(v));
    step(4'd1);
  endtask

  function automatic logic [3:0] scan_an(input int k);
    case (k)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] scan_seg(input int k);
    case (k)
      0: return 7'b1111000;
      1: return 7'b1000001;
      2: return 7'b1111000;
      default: return 7'b0110000;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    sa    = 4'd0;
    clear = 1'b0;
    pin_st("reset", 1'b0, 1'b0, 8'h00, 1'b0);
    pin_dp("reset", 4'b1111, 7'b1111111);
    @(posedge clock);
    #2 reset = 1'b0;

    // Basic sweep
    step(4'd0);
    for (int v = 1; v <= 15; v++) begin
      step(4'(v));
      if (v == 8) pin_st("ascent", 1'b0, 1'b0, 8'h00, 1'b0);
    end
    for (int v = 14; v >= 0; v--) begin
      step(4'(v));
      if (v == 14) pin_st("top", 1'b1, 1'b1, 8'h00, 1'b0);
      if (v == 13) pin_st("top_next", 1'b1, 1'b0, 8'h00, 1'b0);
    end
    step(4'd1);
    pin_st("trough", 1'b0, 1'b0, 8'h01, 1'b0);

    // BCD carry and rollover
    step_clr(4'd1);
    pin_st("clear0", 1'b0, 1'b0, 8'h00, 1'b0);
    for (int n = 1; n <= 100; n++) begin
      sweep();
      case (n)
        9:   pin_st("bcd09", 1'b0, 1'b0, 8'h09, 1'b0);
        10:  pin_st("bcd10", 1'b0, 1'b0, 8'h10, 1'b0);
        99:  pin_st("bcd99", 1'b0, 1'b0, 8'h99, 1'b0);
        100: pin_st("bcd00", 1'b0, 1'b0, 8'h00, 1'b0);
        default: ;
      endcase
    end
    for (int n = 1; n <= 37; n++) sweep();
    pin_st("bcd37", 1'b0, 1'b0, 8'h37, 1'b0);

    // Display scan with cycles=37, dir=0, prev=7
    for (int v = 2; v <= 7; v++) step(4'(v));
    while (edge_cnt % (4 * Div) != 0) step(4'd7);
    for (int i = 0; i < 4 * Div; i++) begin
      step(4'd7);
      pin_dp("scan", scan_an(i / Div), scan_seg(i / Div));
    end

    // Long hold, then illegal jump
    step(4'd8);
    step(4'd9);
    step(4'd10);
    repeat (20) step(4'd10);
    pin_st("hold", 1'b0, 1'b0, 8'h37, 1'b0);
    step(4'd15);
    pin_st("jump_10_15", 1'b0, 1'b0, 8'h37, 1'b1);
    step_clr(4'd15);
    pin_st("clear_err", 1'b0, 1'b0, 8'h00, 1'b0);

    // Skip 5 -> 7 during an ascent
    for (int v = 14; v >= 0; v--) step(4'(v));
    step(4'd1);
    for (int v = 2; v <= 5; v++) step(4'(v));
    step(4'd7);
    pin_st("skip_5_7", 1'b0, 1'b0, 8'h01, 1'b1);
    step(4'd8);
    step(4'd9);
    pin_st("sticky", 1'b0, 1'b0, 8'h01, 1'b1);
    while (edge_cnt % (4 * Div) != Div) step(4'd9);
    step(4'd9);
    pin_dp("err_glyph", 4'b1101, 7'b0000110);
    step_clr(4'd9);
    pin_st("clear_pulse", 1'b0, 1'b0, 8'h00, 1'b0);
    for (int v = 8; v >= 0; v--) step(4'(v));
    step_clr(4'd1);
    pin_st("clear_trough", 1'b0, 1'b0, 8'h00, 1'b0);
    step(4'd1);

    // Reset mid-descent
    sweep();
    for (int v = 2; v <= 15; v++) step(4'(v));
    for (int v = 14; v >= 10; v--) step(4'(v));
    pin_st("descent", 1'b1, 1'b0, 8'h01, 1'b0);
    step(4'd9);
    reset = 1'b1;
    pin_st("async_reset", 1'b0, 1'b0, 8'h00, 1'b0);
    pin_dp("async_reset", 4'b1111, 7'b1111111);
    @(posedge clock);
    #1 reset = 1'b0;
    edge_cnt = 0;
    step(4'd9);
    pin_st("prime", 1'b0, 1'b0, 8'h00, 1'b0);
    pin_dp("prime", 4'b1110, 7'b1000000);
    step(4'd8);
    pin_st("re_peak", 1'b1, 1'b1, 8'h00, 1'b0);
    step(4'd8);
    pin_st("re_hold", 1'b1, 1'b0, 8'h00, 1'b0);
    step(4'd8);
    step(4'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
